// File: rtl/inst_mem_sync.sv
// Byte-addressed little-endian instruction memory: registered 1-cycle fetch port plus byte-wide program-load port.
// Optional macro IMEM_PARITY_EN adds per-byte even parity, a parity_err output and a parity_flip() test hook.
module inst_mem_sync #(
    parameter int          ADDR_WIDTH  = 64,
    parameter int          DEPTH_BYTES = 256,
    parameter int          INST_WIDTH  = 32,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_mode,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [7:0]            prog_data,
    output logic                  prog_err,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  stall,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  inst_fault,
    output logic [31:0]           fetch_count,
    output logic                  dbg_state_o
`ifdef IMEM_PARITY_EN
    ,output logic                 parity_err
`endif
);

    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD_A = ADDR_WIDTH'(DEPTH_BYTES - 4);

    generate
        if (INST_WIDTH != 32 || (DEPTH_BYTES % 4) != 0 || DEPTH_BYTES < 4) begin : g_param_check
            $error("inst_mem_sync: INST_WIDTH must be 32 and DEPTH_BYTES a non-zero multiple of 4");
        end
    endgenerate

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [7:0] mem [DEPTH_BYTES];

    logic                  valid_q, valid_d;
    logic [INST_WIDTH-1:0] instr_q, instr_d;
    logic                  fault_q, fault_d;
    logic [31:0]           count_q, count_d;
    logic                  perr_q, perr_d;

    logic                  wr_en;
    logic                  wr_oob;
    logic                  fetch_acc;
    logic                  fetch_bad;
    logic [IDX_W-1:0]      widx;
    logic [IDX_W-1:0]      ridx0, ridx1, ridx2, ridx3;
    logic [INST_WIDTH-1:0] rd_word;
    logic                  rd_par_bad;

    // Full-width compares so that high address bits can never alias into the array.
    assign wr_oob    = prog_addr >= DEPTH_A;
    assign wr_en     = prog_mode && prog_we && !wr_oob;
    assign fetch_acc = !prog_mode && !stall && fetch_req;
    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_WORD_A);

    assign widx  = prog_addr[IDX_W-1:0];
    assign ridx0 = fetch_addr[IDX_W-1:0];
    assign ridx1 = ridx0 + IDX_W'(1);
    assign ridx2 = ridx0 + IDX_W'(2);
    assign ridx3 = ridx0 + IDX_W'(3);
    assign rd_word = {mem[ridx3], mem[ridx2], mem[ridx1], mem[ridx0]};

`ifdef IMEM_PARITY_EN
    logic par_q [DEPTH_BYTES];
    logic perr_out_q, perr_out_d;

    assign rd_par_bad = ((^mem[ridx0]) != par_q[ridx0]) || ((^mem[ridx1]) != par_q[ridx1]) ||
                        ((^mem[ridx2]) != par_q[ridx2]) || ((^mem[ridx3]) != par_q[ridx3]);

    // Backdoor used by the bench to corrupt a stored parity bit.
    task automatic parity_flip(input logic [ADDR_WIDTH-1:0] addr);
        par_q[addr[IDX_W-1:0]] = ~par_q[addr[IDX_W-1:0]];
    endtask
`else
    assign rd_par_bad = 1'b0;
`endif

    // Memory is deliberately outside the reset domain so programs survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[widx] <= prog_data;
`ifdef IMEM_PARITY_EN
            par_q[widx] <= ^prog_data;
`endif
        end
    end

    always_comb begin
        state_d = prog_mode ? ST_LOAD : ST_RUN;
        valid_d = valid_q;
        instr_d = instr_q;
        fault_d = fault_q;
        count_d = count_q;
        perr_d  = 1'b0;
`ifdef IMEM_PARITY_EN
        perr_out_d = perr_out_q;
`endif
        if (prog_mode) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            fault_d = 1'b0;
            perr_d  = prog_we && wr_oob;
`ifdef IMEM_PARITY_EN
            perr_out_d = 1'b0;
`endif
        end else if (!stall) begin
            valid_d = fetch_acc;
            fault_d = fetch_acc && fetch_bad;
`ifdef IMEM_PARITY_EN
            perr_out_d = fetch_acc && !fetch_bad && rd_par_bad;
`endif
            if (fetch_acc) begin
                count_d = count_q + 32'd1;
                instr_d = fetch_bad ? NOP_WORD : rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            fault_q <= 1'b0;
            count_q <= 32'd0;
            perr_q  <= 1'b0;
`ifdef IMEM_PARITY_EN
            perr_out_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            count_q <= count_d;
            perr_q  <= perr_d;
`ifdef IMEM_PARITY_EN
            perr_out_q <= perr_out_d;
`endif
        end
    end

    assign inst_valid  = valid_q;
    assign instruction = instr_q;
    assign inst_fault  = fault_q;
    assign fetch_count = count_q;
    assign prog_err    = perr_q;
    assign dbg_state_o = state_q;
`ifdef IMEM_PARITY_EN
    assign parity_err  = perr_out_q;
`endif

    // rd_par_bad only feeds logic in the parity build.
    logic unused_ok;
    assign unused_ok = rd_par_bad;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Bench for inst_mem_sync: directed vector table for the documented scenarios, then random traffic vs a byte-array model.
module tb_inst_mem_sync;

    localparam int          AW    = 64;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          prog_mode = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [7:0]    prog_data = '0;
    logic          prog_err;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          stall = 1'b0;
    logic          inst_valid;
    logic [31:0]   instruction;
    logic          inst_fault;
    logic [31:0]   fetch_count;
    logic          dbg_state_o;
`ifdef IMEM_PARITY_EN
    logic          parity_err;
`endif

    inst_mem_sync #(.ADDR_WIDTH(AW), .DEPTH_BYTES(DEPTH), .INST_WIDTH(32), .NOP_WORD(NOP)) u_dut (
        .clk(clk), .reset(reset),
        .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_err(prog_err),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
        .inst_valid(inst_valid), .instruction(instruction), .inst_fault(inst_fault),
        .fetch_count(fetch_count), .dbg_state_o(dbg_state_o)
`ifdef IMEM_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: plain byte array plus the expected registered outputs
    logic [7:0]  m_mem [DEPTH];
    logic        m_valid, m_fault, m_perr, m_state;
    logic [31:0] m_instr, m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the documented rules, sample #1 after the edge.
    task automatic step(input logic rst, input logic mode, input logic we, input logic [AW-1:0] pa,
                        input logic [7:0] pd, input logic req, input logic [AW-1:0] fa, input logic stl);
        reset = rst; prog_mode = mode; prog_we = we; prog_addr = pa; prog_data = pd;
        fetch_req = req; fetch_addr = fa; stall = stl;
        if (rst) begin
            m_valid = 0; m_instr = NOP; m_fault = 0; m_perr = 0; m_cnt = 0; m_state = 0;
        end else if (mode) begin
            m_valid = 0; m_instr = NOP; m_fault = 0; m_perr = we && (pa >= AW'(DEPTH)); m_state = 1;
        end else begin
            m_perr = 0; m_state = 0;
            if (!stl) begin
                m_valid = req;
                m_fault = 0;
                if (req) begin
                    m_cnt = m_cnt + 1;
                    if ((fa % 4) != 0 || fa > AW'(DEPTH - 4)) begin
                        m_fault = 1; m_instr = NOP;
                    end else begin
                        m_instr = {m_mem[fa + 3], m_mem[fa + 2], m_mem[fa + 1], m_mem[fa]};
                    end
                end
            end
        end
        if (mode && we && pa < AW'(DEPTH)) m_mem[pa] = pd;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst, mode, we;
        logic [AW-1:0] pa;
        logic [7:0]    pd;
        logic          req;
        logic [AW-1:0] fa;
        logic          stl;
        logic          e_valid;
        logic [31:0]   e_instr;
        logic          chk_instr;
        logic          e_fault, e_perr;
        logic [31:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    //                    rst mode we pa  pd   req fa  stl | valid instr chk fault perr cnt
    task automatic row(input logic rst, input logic mode, input logic we, input logic [AW-1:0] pa,
                       input logic [7:0] pd, input logic req, input logic [AW-1:0] fa, input logic stl,
                       input logic ev, input logic [31:0] ei, input logic ci, input logic ef,
                       input logic ep, input logic [31:0] ec);
        vec_t v;
        v = '{rst, mode, we, pa, pd, req, fa, stl, ev, ei, ci, ef, ep, ec};
        vecs.push_back(v);
    endtask

    logic [7:0] prog_bytes [8];

    initial begin
        prog_bytes = '{8'h93, 8'h05, 8'h80, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00};

        // preload every byte with random data so any in-range fetch is predictable
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, AW'(i), 8'($urandom), 0, 0, 0);

        row(1, 0, 0, 0, 0, 0, 0, 0,  0, NOP, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) row(0, 1, 1, AW'(i), prog_bytes[i], 0, 0, 0,  0, NOP, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0,  0, NOP, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h0080_0593, 1, 0, 0, 1);
        row(0, 0, 0, 0, 0, 1, 2, 0,  1, NOP, 1, 1, 0, 2);
        row(0, 0, 0, 0, 0, 1, 256, 0,  1, NOP, 1, 1, 0, 3);
        row(0, 0, 0, 0, 0, 1, 252, 0,  1, NOP, 0, 0, 0, 4);
        row(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h0080_0593, 1, 0, 0, 5);
        for (int i = 0; i < 3; i++) row(0, 0, 0, 0, 0, 1, 4, 1,  1, 32'h0080_0593, 1, 0, 0, 5);
        row(0, 0, 0, 0, 0, 1, 4, 0,  1, 32'h00a0_0513, 1, 0, 0, 6);
        row(0, 0, 0, 0, 0, 0, 4, 0,  0, 32'h00a0_0513, 1, 0, 0, 6);
        row(0, 1, 1, 300, 8'hff, 0, 0, 0,  0, NOP, 1, 0, 1, 6);
        row(0, 1, 0, 0, 0, 0, 0, 0,  0, NOP, 1, 0, 0, 6);
        row(0, 0, 1, 5, 8'hff, 0, 0, 0,  0, NOP, 1, 0, 0, 6);
        row(0, 0, 0, 0, 0, 1, 4, 0,  1, 32'h00a0_0513, 1, 0, 0, 7);
        row(0, 1, 0, 0, 0, 1, 4, 1,  0, NOP, 1, 0, 0, 7);
        row(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h0080_0593, 1, 0, 0, 8);
        row(1, 0, 0, 0, 0, 1, 4, 0,  0, NOP, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h0080_0593, 1, 0, 0, 1);
        row(0, 0, 0, 0, 0, 1, 64'h1000_0000_0000_0000, 0,  1, NOP, 1, 1, 0, 2);
        row(0, 0, 0, 0, 0, 1, 64'h0000_0001_0000_0000, 0,  1, NOP, 1, 1, 0, 3);
        // reset wins over outputs but a write in the same cycle still lands
        row(1, 1, 1, 8, 8'h11, 0, 0, 0,  0, NOP, 1, 0, 0, 0);
        row(0, 1, 1, 9, 8'h22, 0, 0, 0,  0, NOP, 1, 0, 0, 0);
        row(0, 1, 1, 10, 8'h33, 0, 0, 0,  0, NOP, 1, 0, 0, 0);
        row(0, 1, 1, 11, 8'h44, 0, 0, 0,  0, NOP, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 8, 0,  1, 32'h4433_2211, 1, 0, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].mode, vecs[i].we, vecs[i].pa, vecs[i].pd,
                 vecs[i].req, vecs[i].fa, vecs[i].stl);
            chk($sformatf("vec%0d inst_valid", i), 64'(inst_valid), 64'(vecs[i].e_valid));
            if (vecs[i].chk_instr)
                chk($sformatf("vec%0d instruction", i), 64'(instruction), 64'(vecs[i].e_instr));
            chk($sformatf("vec%0d inst_fault", i), 64'(inst_fault), 64'(vecs[i].e_fault));
            chk($sformatf("vec%0d prog_err", i), 64'(prog_err), 64'(vecs[i].e_perr));
            chk($sformatf("vec%0d fetch_count", i), 64'(fetch_count), 64'(vecs[i].e_cnt));
        end

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic          r_rst, r_mode, r_we, r_req, r_stl;
            logic [AW-1:0] r_pa, r_fa;
            int            sel;
            r_rst  = ($urandom_range(0, 49) == 0);
            r_mode = ($urandom_range(0, 4) == 0);
            r_we   = $urandom_range(0, 1) == 1;
            r_pa   = ($urandom_range(0, 5) == 0) ? {32'($urandom), 32'($urandom)} : AW'($urandom_range(0, 300));
            r_req  = ($urandom_range(0, 9) < 7);
            r_stl  = ($urandom_range(0, 4) == 0);
            sel    = $urandom_range(0, 9);
            if (sel < 6)      r_fa = AW'($urandom_range(0, DEPTH / 4 - 1) * 4);
            else if (sel < 9) r_fa = AW'($urandom_range(0, DEPTH + 8));
            else              r_fa = {32'($urandom), 32'($urandom)};
            step(r_rst, r_mode, r_we, r_pa, 8'($urandom), r_req, r_fa, r_stl);
            chk("rnd inst_valid", 64'(inst_valid), 64'(m_valid));
            chk("rnd instruction", 64'(instruction), 64'(m_instr));
            chk("rnd inst_fault", 64'(inst_fault), 64'(m_fault));
            chk("rnd prog_err", 64'(prog_err), 64'(m_perr));
            chk("rnd fetch_count", 64'(fetch_count), 64'(m_cnt));
            chk("rnd state", 64'(dbg_state_o), 64'(m_state));
`ifdef IMEM_PARITY_EN
            chk("rnd parity_err", 64'(parity_err), 64'(0));
`endif
        end

`ifdef IMEM_PARITY_EN
        step(0, 0, 0, 0, 0, 0, 0, 0);
        u_dut.parity_flip(1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("par flip parity_err", 64'(parity_err), 64'(1));
        chk("par flip instruction raw", 64'(instruction), 64'(m_instr));
        step(0, 0, 0, 0, 0, 1, 4, 0);
        chk("par clean parity_err", 64'(parity_err), 64'(0));
        chk("par clean instruction", 64'(instruction), 64'(m_instr));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
Parametrised, byte-addressed, little-endian instruction memory with a registered 1-cycle fetch port and a byte-wide program-load port. The fetch port feeds the IF stage of the RISC-V core and supports stall-hold and fault reporting. The load port lets the testbench or boot logic write programs at run time instead of using fixed initial contents. It replaces the combinational fixed-program instruction store.

Parameters:
ADDR_WIDTH, 64, width of fetch_addr and prog_addr
DEPTH_BYTES, 256, memory size in bytes; must be a multiple of 4
INST_WIDTH, 32, instruction width in bits; fixed at 32, asserted at elaboration
NOP_WORD, 32'h00000013, word driven on reset, on faults and in load mode (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
prog_mode  in  1  1 = load mode: fetch is blocked and writes are accepted
prog_we  in  1  byte write strobe; effective only while prog_mode=1
prog_addr  in  ADDR_WIDTH  byte address for the write
prog_data  in  8  byte to write
prog_err  out  1  1-cycle pulse when a write is attempted out of range
fetch_req  in  1  fetch request from IF
fetch_addr  in  ADDR_WIDTH  byte address of the instruction (PC)
stall  in  1  hold the fetch outputs and ignore fetch_req
inst_valid  out  1  instruction/inst_fault are valid this cycle
instruction  out  32  fetched word, little-endian
inst_fault  out  1  misaligned or out-of-range fetch
fetch_count  out  32  count of accepted fetches, faulting ones included

Behaviour:
- Reset values: inst_valid=0, instruction=NOP_WORD, inst_fault=0, prog_err=0, fetch_count=0. Memory contents are NOT cleared by reset.
- Modes: there are two states, RUN (prog_mode=0) and LOAD (prog_mode=1). The state follows prog_mode, registered.
- Entering LOAD:
  - the next cycle gives inst_valid=0 and instruction=NOP_WORD;
  - this holds even when stall=1, because load mode overrides stall.
- Write (LOAD state):
  - prog_we=1 and prog_addr < DEPTH_BYTES writes mem[prog_addr]=prog_data at the edge;
  - when prog_addr >= DEPTH_BYTES, no write happens and prog_err=1 in the next cycle only;
  - prog_we while prog_mode=0 is ignored silently, with no prog_err.
- Fetch acceptance: a fetch is accepted when prog_mode=0, stall=0 and fetch_req=1. Latency is exactly 1 cycle. On the next cycle:
  - inst_valid=1;
  - instruction = {mem[a+3],mem[a+2],mem[a+1],mem[a]}, where a = fetch_addr;
  - fetch_count increments by 1 and wraps from 2^32-1 to 0.
- Fault: when fetch_addr[1:0]!=0 or fetch_addr > DEPTH_BYTES-4, the response is:
  - inst_fault=1, inst_valid=1, instruction=NOP_WORD;
  - no memory access;
  - the full ADDR_WIDTH compare applies, so upper address bits are not truncated.
- No request (prog_mode=0, stall=0, fetch_req=0): next cycle inst_valid=0 and inst_fault=0; instruction holds its last value.
- Stall: stall=1 in RUN holds inst_valid, instruction, inst_fault and fetch_count unchanged, and fetch_req is ignored.
- Read-after-write: a byte written in cycle N is visible to a fetch accepted in cycle N+1 or later. A write and a fetch in the same cycle cannot happen, because the modes are mutually exclusive.
- Reset mid-operation: reset wins over every other input in its cycle. A pending write in that cycle is still performed, since memory is not reset. The cycle after reset gives the reset output values.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - each byte stores an even-parity bit computed on write;
  - an accepted in-range fetch recomputes parity over its 4 bytes;
  - a mismatch sets an extra output parity_err=1 together with that response;
  - instruction still returns the raw data;
  - a task/backdoor hook parity_flip(addr) corrupts the stored parity bit for test.
- Undefined: no parity storage and no parity_err port.

Test Plan:
- Load bytes 93,05,80,00 at 0..3, drop prog_mode, fetch addr 0 -> next cycle inst_valid=1, instruction=32'h00800593, fetch_count=1.
- Fetch addr 2 -> inst_fault=1, instruction=32'h00000013; fetch addr 256 with DEPTH_BYTES=256 -> inst_fault=1; fetch addr 252 -> valid, no fault.
- Fetch addr 0, then stall=1 for 3 cycles with fetch_req=1, addr 4 -> outputs frozen at the addr-0 response, fetch_count unchanged; release stall -> addr-4 word 1 cycle later.
- prog_mode=1, prog_we=1, prog_addr=300 -> prog_err pulses 1 cycle, memory unchanged; prog_we with prog_mode=0 -> no write, no prog_err.
- Mid-stream reset=1 for one cycle -> all outputs at reset values; a fetch of addr 0 afterwards returns the previously loaded word, confirming memory is retained.
- With IMEM_PARITY_EN: parity_flip(1), fetch addr 0 -> parity_err=1, instruction raw; fetch addr 4 -> parity_err=0.
